// File: rtl/c_mips_pkg.sv
// Shared types and constants for the MIPS instruction loader slice.
//   loader_state_t : loader FSM encoding (S_IDLE, S_LOAD, S_READY)
//   INS_W          : instruction word width
//   NOP_INS        : word returned when a fetch is suppressed
package c_mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } loader_state_t;

    localparam int          INS_W   = 32;
    localparam logic [31:0] NOP_INS = 32'h0000_0000;

endpackage

// File: rtl/c_ins_ram.sv
// Instruction memory: DEPTH x INS_W, one write port, one registered read port.
// The array has no reset so a loaded program survives a chip reset.
// Ports:
//   clk        : clock, rising edge
//   i_we       : write enable
//   i_waddr    : write word address
//   i_wdata    : write data
//   i_raddr    : read word address
//   o_rdata    : read data, one cycle after i_raddr
module c_ins_ram
    import c_mips_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [INS_W-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [INS_W-1:0]         o_rdata
);

    logic [INS_W-1:0] mem_q [DEPTH];
    logic [INS_W-1:0] rdata_q;

    // Array write and registered read; no reset on purpose.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/c_ins_loader.sv
// Chip-side receiver for the program-mode instruction stream. Stores one
// word per clock at an auto-incrementing address and serves the IF stage
// with a 1-cycle-latency fetch read outside of loading.
// Optional feature macro: LOADER_CHECKSUM_EN adds o_checksum (running
// mod-2^32 sum of the accepted words of the current/last load).
// Ports:
//   i_c_sys_clock   : clock, rising edge
//   i_c_sys_reset_n : synchronous active-low reset (memory contents kept)
//   i_ins_wr        : program-mode strobe, one word per high edge
//   i_write_ins     : word to store
//   i_fetch_addr    : IF-stage byte address
//   o_fetch_ins     : fetched word (NOP when suppressed), 1 cycle latency
//   o_load_busy     : state is S_LOAD
//   o_load_done     : state is S_READY
//   o_word_count    : words accepted in current/last load, saturates at DEPTH
//   o_overflow      : sticky, a word arrived with the memory full
//   o_checksum      : (LOADER_CHECKSUM_EN only) sum of accepted words
module c_ins_loader
    import c_mips_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   i_c_sys_clock,
    input  logic                   i_c_sys_reset_n,
    input  logic                   i_ins_wr,
    input  logic [31:0]            i_write_ins,
    input  logic [31:0]            i_fetch_addr,
    output logic [31:0]            o_fetch_ins,
    output logic                   o_load_busy,
    output logic                   o_load_done,
    output logic [$clog2(DEPTH):0] o_word_count,
    output logic                   o_overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]            o_checksum
`endif
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_PTR = (AW + 1)'(DEPTH);

    loader_state_t state_q, state_d;
    // Write pointer and accepted-word count always coincide (both start at 1
    // on load entry and stop at DEPTH), so one register serves both.
    logic [AW:0]   ptr_q, ptr_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          nop_q, nop_d;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [31:0]   rdata_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^i_fetch_addr[1:0];

    // Next-state, write control and fetch gating.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        we_s    = 1'b0;
        waddr_s = ptr_q[AW-1:0];
        case (state_q)
            S_IDLE, S_READY: begin
                if (i_ins_wr) begin
                    // Load start (also reprogram from READY) always restarts at mem[0].
                    we_s    = 1'b1;
                    waddr_s = {AW{1'b0}};
                    ptr_d   = {{AW{1'b0}}, 1'b1};
                    ovf_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (i_ins_wr) begin
                    if (ptr_q != FULL_PTR) begin
                        we_s  = 1'b1;
                        ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    state_d = S_READY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Reset wins over a strobe in the same cycle: nothing is written.
        if (!i_c_sys_reset_n) begin
            state_d = S_IDLE;
            ptr_d   = {(AW + 1){1'b0}};
            ovf_d   = 1'b0;
            we_s    = 1'b0;
        end else begin
            state_d = state_d;
        end
        busy_d = (state_d == S_LOAD);
        done_d = (state_d == S_READY);
        nop_d  = (i_fetch_addr[31:AW+2] != '0) || (state_q == S_LOAD) || we_s;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge i_c_sys_clock) begin
        if (!i_c_sys_reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= {(AW + 1){1'b0}};
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nop_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nop_q   <= nop_d;
        end
    end

    c_ins_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (i_c_sys_clock),
        .i_we    (we_s),
        .i_waddr (waddr_s),
        .i_wdata (i_write_ins),
        .i_raddr (i_fetch_addr[AW+1:2]),
        .o_rdata (rdata_s)
    );

    // nop_q is registered alongside the RAM read, so the mux sees aligned data.
    assign o_fetch_ins  = nop_q ? NOP_INS : rdata_s;
    assign o_load_busy  = busy_q;
    assign o_load_done  = done_q;
    assign o_word_count = ptr_q;
    assign o_overflow   = ovf_q;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    // Checksum restarts with the first word of a load and accumulates accepted words.
    always_comb begin
        csum_d = csum_q;
        if (we_s && (state_q != S_LOAD)) begin
            csum_d = i_write_ins;
        end else if (we_s) begin
            csum_d = csum_q + i_write_ins;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge i_c_sys_clock) begin
        if (!i_c_sys_reset_n) begin
            csum_q <= 32'h0000_0000;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign o_checksum = csum_q;
`endif

endmodule
